variable_node_serial: RTL and testbench
=======================================

// Module: variable_node_serial
// PURPOSE
//  Edge-serial, parametrised variable-node unit for the NN min-sum decoder
//  (odd-layer update).
//  - Consumes the check-to-variable messages of one variable node (VN) at a time
//    over a valid/ready stream, together with that VN's channel LLR.
//  - Emits the VN's extrinsic variable-to-check messages in arrival order, plus a
//    hard decision for the VN.
//  - Sits between the check-node unit output and the edge message memory.
//  - Arbitrary VN degree up to MAX_DEG.
//  - Saturating fixed-point arithmetic replaces the unbounded combinational
//    sums of the previous generation.
// PARAMETERS
//  W_LLR    8   signed channel-LLR width (bits)
//  W_MSG    8   signed message width, in and out (bits)
//  MAX_DEG  16  maximum VN degree (edges per group); also buffer depth
//  W_ACC    W_MSG+$clog2(MAX_DEG+1)+1  accumulator width (localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      unit can accept a beat
//  in_llr     in   W_LLR  channel LLR of current VN; sampled on first beat of a group only
//  in_msg     in   W_MSG  check-to-variable message (signed)
//  in_last    in   1      beat is the last edge of the current VN
//  out_valid  out  1      extrinsic message valid
//  out_ready  in   1      downstream accepts message
//  out_msg    out  W_MSG  extrinsic variable-to-check message (signed, saturated)
//  out_last   out  1      message is the last of the group
//  hd_valid   out  1      one-cycle pulse: hd_bit valid
//  hd_bit     out  1      hard decision: 1 iff total posterior < 0
//  deg_err    out  1      sticky: group reached MAX_DEG beats without in_last
// BEHAVIOUR
//  - Reset (async, any state, incl. mid-group): state=ACCUM, counters=0,
//    acc=0, in_ready=1, out_valid=0, out_last=0, out_msg=0, hd_valid=0,
//    hd_bit=0, deg_err=0. Any partial group is discarded; no output emitted for it.
//  - FSM states: ACCUM, EMIT.
//  - ACCUM:
//    - in_ready=1, out_valid=0.
//    - Beat accepted on in_valid&in_ready.
//    - First beat (cnt==0): acc <= sext(in_llr)+sext(in_msg).
//    - Later beats: acc <= acc+sext(in_msg).
//    - Every accepted beat writes in_msg to buf[cnt] and increments cnt.
//    - Accepted beat with in_last, or with cnt==MAX_DEG-1, -> EMIT next cycle.
//      The MAX_DEG-1 case without in_last also sets deg_err.
//  - Entry to EMIT:
//    - hd_valid pulses high for exactly the first EMIT cycle.
//    - hd_bit <= (final acc < 0), held until next group.
//  - EMIT:
//    - in_ready=0, out_valid=1.
//    - out_msg = sat(acc - sext(buf[rd])); out_last = (rd==cnt-1).
//    - Outputs stable while out_valid&!out_ready.
//    - On handshake rd increments.
//    - On handshake with out_last: rd=cnt=0, state -> ACCUM the next cycle.
//      No overlap: first beat of the next group is accepted no earlier than
//      one cycle after that handshake.
//  - Latency: first out_valid 1 cycle after the last input handshake. Throughput:
//    degree d costs d input + d output cycles (min) + 0 idle.
//  - Arithmetic:
//    - acc is W_ACC-bit signed and never overflows, for W_LLR<=W_MSG+1.
//    - sat() clamps symmetrically to [-(2^(W_MSG-1)-1), +(2^(W_MSG-1)-1)].
//    - The most-negative code is never produced.
//  - Degree-1 VN: out_msg = sat(llr). Inputs are taken as-is; -2^(W_MSG-1)
//    input is legal.
//  - deg_err clears only on reset. in_llr on non-first beats is ignored.
// TESTING (W_LLR=W_MSG=8, MAX_DEG=4 unless noted)
//  1 Basic: llr=10, msgs 5,-3,7(last), out_ready=1.
//    -> out 14,22,12; out_last on 12; hd_valid pulse, hd_bit=0.
//  2 Saturation: llr=100, msgs 100,100(last) -> total 300; outs 127,127; hd_bit=0.
//    Repeat negated -> -127,-127; hd_bit=1.
//  3 Backpressure: scenario 1 with out_ready toggling 1,0,0,1,...
//    -> same 3 values in order, each held stable while stalled; in_ready=0 throughout EMIT.
//  4 Degree 1 + back-to-back: group A {llr=-20, msg 9 last}, then B {llr=3, msgs -1,-1 last}.
//    -> A outputs -20, hd=1.
//    -> B outputs 2,2, hd=0; B's first beat not accepted in A's final handshake cycle.
//  5 Overflow: 4 beats without in_last, msgs all 1, llr=0 -> deg_err=1; outputs 3,3,3,3 with out_last on 4th.
//  6 Reset mid-op: assert rst after 2 beats of a group, and again while out_valid stalled.
//    -> outputs cleared asynchronously, in_ready=1.
//    -> the next fresh group {llr=1, msg 1 last} yields out 1.

Source files
------------

// File: rtl/variable_node_serial_if.sv
// Stream interface of the edge-serial variable-node unit: input edge beats,
// extrinsic output messages and per-VN status.
interface variable_node_serial_if #(
  parameter int W_LLR = 8,
  parameter int W_MSG = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W_LLR-1:0] in_llr;
  logic [W_MSG-1:0] in_msg;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W_MSG-1:0] out_msg;
  logic             out_last;
  logic             hd_valid;
  logic             hd_bit;
  logic             deg_err;

  modport master (
    output in_valid, in_llr, in_msg, in_last, out_ready,
    input  in_ready, out_valid, out_msg, out_last, hd_valid, hd_bit, deg_err
  );

  modport slave (
    input  in_valid, in_llr, in_msg, in_last, out_ready,
    output in_ready, out_valid, out_msg, out_last, hd_valid, hd_bit, deg_err
  );
endinterface

// File: rtl/variable_node_serial.sv
// Edge-serial min-sum variable-node unit: accumulates one VN's check messages,
// then replays them as saturated extrinsic messages plus a hard decision.
module variable_node_serial #(
  parameter int W_LLR   = 8,
  parameter int W_MSG   = 8,
  parameter int MAX_DEG = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  variable_node_serial_if.slave bus
);
  localparam int W_ACC = W_MSG + $clog2(MAX_DEG + 1) + 1;
  localparam int CW    = $clog2(MAX_DEG + 1);
  localparam int IW    = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;
  localparam logic signed [W_ACC:0] SAT_MAX = (W_ACC + 1)'((1 <<< (W_MSG - 1)) - 1);
  localparam logic signed [W_ACC:0] SAT_MIN = -SAT_MAX;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           rd_q, rd_d;
  logic signed [W_ACC-1:0] acc_q, acc_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    hd_valid_q, hd_valid_d;
  logic                    hd_bit_q, hd_bit_d;
  logic                    deg_err_q, deg_err_d;

  logic [W_MSG-1:0]        msg_buf [MAX_DEG];
  logic                    accept, take_out;
  logic signed [W_ACC-1:0] llr_ext, msg_ext, rd_ext;
  logic signed [W_ACC:0]   diff;
  logic [W_MSG-1:0]        out_msg_c;

  assign accept   = bus.in_valid & in_ready_q;
  assign take_out = out_valid_q & bus.out_ready;
  assign llr_ext  = W_ACC'($signed(bus.in_llr));
  assign msg_ext  = W_ACC'($signed(bus.in_msg));
  assign rd_ext   = W_ACC'($signed(msg_buf[rd_q[IW-1:0]]));

  // Extrinsic message: posterior minus this edge's own input, clamped symmetrically.
  always_comb begin
    diff = (W_ACC + 1)'(acc_q) - (W_ACC + 1)'(rd_ext);
    out_msg_c = '0;
    if (out_valid_q) begin
      if (diff > SAT_MAX)      out_msg_c = SAT_MAX[W_MSG-1:0];
      else if (diff < SAT_MIN) out_msg_c = SAT_MIN[W_MSG-1:0];
      else                     out_msg_c = diff[W_MSG-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    hd_valid_d  = 1'b0;
    hd_bit_d    = hd_bit_q;
    deg_err_d   = deg_err_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          acc_d = (cnt_q == '0) ? (llr_ext + msg_ext) : (acc_q + msg_ext);
          if (bus.in_last || (cnt_q == CW'(MAX_DEG - 1))) begin
            state_d     = EMIT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == '0);
            rd_d        = '0;
            hd_valid_d  = 1'b1;
            hd_bit_d    = acc_d[W_ACC-1];
            if (!bus.in_last) deg_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (take_out) begin
          if (out_last_q) begin
            state_d     = ACCUM;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_d        = '0;
            cnt_d       = '0;
          end else begin
            rd_d       = rd_q + 1'b1;
            out_last_d = (rd_d == cnt_q - 1'b1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      rd_q        <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      hd_valid_q  <= 1'b0;
      hd_bit_q    <= 1'b0;
      deg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      hd_valid_q  <= hd_valid_d;
      hd_bit_q    <= hd_bit_d;
      deg_err_q   <= deg_err_d;
    end
  end

  // Edge buffer needs no reset: entries are always written before being read.
  always_ff @(posedge clk) begin
    if (accept) msg_buf[cnt_q[IW-1:0]] <= bus.in_msg;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_msg   = out_msg_c;
  assign bus.out_last  = out_last_q;
  assign bus.hd_valid  = hd_valid_q;
  assign bus.hd_bit    = hd_bit_q;
  assign bus.deg_err   = deg_err_q;
endmodule

// File: tb/tb_variable_node_serial.sv
// Self-checking bench for variable_node_serial: directed scenarios plus random
// groups, checked every cycle against a queue-based behavioural model.
module tb_variable_node_serial;
  localparam int W_LLR   = 8;
  localparam int W_MSG   = 8;
  localparam int MAX_DEG = 4;
  localparam int SATV    = 127;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  variable_node_serial_if #(.W_LLR(W_LLR), .W_MSG(W_MSG)) bus ();

  variable_node_serial #(.W_LLR(W_LLR), .W_MSG(W_MSG), .MAX_DEG(MAX_DEG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {int msg; bit last;} out_t;

  int   errors = 0;
  int   checks = 0;
  out_t exp_q[$];
  bit   exp_hd[$];
  bit   hd_hold;
  bit   deg_exp;
  int   cur_llr;
  int   cur_msgs[$];
  int   seen[$];
  int   rdy_mode;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > SATV) return SATV;
    if (v < -SATV) return -SATV;
    return v;
  endfunction

  // Posterior = llr + sum of all messages; each extrinsic = posterior minus own edge.
  function automatic void model_outs(input int llr, input int msgs[$],
                                     output int outs[$], output bit hd);
    int total;
    total = llr;
    foreach (msgs[i]) total += msgs[i];
    outs.delete();
    foreach (msgs[i]) outs.push_back(clamp(total - msgs[i]));
    hd = (total < 0);
  endfunction

  function automatic void finalize_group();
    int outs[$];
    bit hd;
    model_outs(cur_llr, cur_msgs, outs, hd);
    foreach (outs[i]) begin
      out_t o;
      o.msg  = outs[i];
      o.last = (i == outs.size() - 1);
      exp_q.push_back(o);
    end
    exp_hd.push_back(hd);
    cur_msgs.delete();
  endfunction

  function automatic int rnd8();
    logic [7:0] r;
    r = 8'($urandom);
    return int'($signed(r));
  endfunction

  task automatic monitor();
    int v;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_msg", int'(bus.out_msg), 0);
        chk("rst_hd_valid", bus.hd_valid, 0);
        chk("rst_hd_bit", bus.hd_bit, 0);
        chk("rst_deg_err", bus.deg_err, 0);
        exp_q.delete();
        exp_hd.delete();
        cur_msgs.delete();
        hd_hold = 1'b0;
        deg_exp = 1'b0;
      end else begin
        chk("deg_err", bus.deg_err, deg_exp);
        chk("in_ready_vs_out_valid", bus.in_ready, !bus.out_valid);
        if (bus.hd_valid) begin
          chk("hd_pending", int'(exp_hd.size() > 0), 1);
          if (exp_hd.size() > 0) hd_hold = exp_hd.pop_front();
        end
        chk("hd_bit", bus.hd_bit, hd_hold);
        if (bus.out_valid) begin
          chk("out_pending", int'(exp_q.size() > 0), 1);
          v = $signed(bus.out_msg);
          if (exp_q.size() > 0) begin
            chk("out_msg", v, exp_q[0].msg);
            chk("out_last", bus.out_last, exp_q[0].last);
            if (bus.out_ready) begin
              seen.push_back(v);
              void'(exp_q.pop_front());
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          if (cur_msgs.size() == 0) cur_llr = $signed(bus.in_llr);
          v = $signed(bus.in_msg);
          cur_msgs.push_back(v);
          if (bus.in_last || cur_msgs.size() == MAX_DEG) begin
            if (!bus.in_last) deg_exp = 1'b1;
            finalize_group();
          end
        end
      end
    end
  endtask

  task automatic rdy_drive();
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (ph == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
      ph = (ph == 2) ? 0 : ph + 1;
    end
  endtask

  // Called in the posedge+1 phase; returns in the same phase.
  task automatic send_group(input int llr, input int msgs[$], input bit with_last,
                            input int gap_max);
    bit got;
    int budget;
    foreach (msgs[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_llr   = (i == 0) ? W_LLR'(llr) : W_LLR'($urandom);
      bus.in_msg   = W_MSG'(msgs[i]);
      bus.in_last  = with_last && (i == msgs.size() - 1);
      budget = 0;
      do begin
        @(negedge clk);
        got = bus.in_ready;
        @(posedge clk);
        #1;
        budget++;
      end while (!got && budget < 300);
      if (!got) chk("in_accept_timeout", got, 1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() > 0 || bus.out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_pending", exp_q.size() + exp_hd.size(), 0);
  endtask

  task automatic chk_seen(input string name, input int req[$]);
    chk({name, "_count"}, seen.size(), req.size());
    foreach (req[i]) if (i < seen.size()) chk(name, seen[i], req[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int outs[$];
    int req[$];
    int msgs[$];
    bit hd;
    int n;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_llr    = '0;
    bus.in_msg    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rdy_mode = 0;
    fork
      monitor();
      rdy_drive();
    join_none
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the model with hand-computed values.
    model_outs(10, '{5, -3, 7}, outs, hd);
    chk("pin1_a", outs[0], 14); chk("pin1_b", outs[1], 22); chk("pin1_c", outs[2], 12);
    chk("pin1_hd", hd, 0);
    model_outs(-100, '{-100, -100}, outs, hd);
    chk("pin2_a", outs[0], -127); chk("pin2_hd", hd, 1);
    model_outs(-20, '{9}, outs, hd);
    chk("pin4_a", outs[0], -20);

    // 1: basic
    seen.delete();
    send_group(10, '{5, -3, 7}, 1, 0);
    wait_idle();
    chk_seen("s1", '{14, 22, 12});
    chk("s1_hd_bit", bus.hd_bit, 0);

    // 2: saturation, both signs
    seen.delete();
    send_group(100, '{100, 100}, 1, 0);
    wait_idle();
    chk_seen("s2p", '{127, 127});
    chk("s2p_hd_bit", bus.hd_bit, 0);
    seen.delete();
    send_group(-100, '{-100, -100}, 1, 0);
    wait_idle();
    chk_seen("s2n", '{-127, -127});
    chk("s2n_hd_bit", bus.hd_bit, 1);

    // 3: backpressure
    rdy_mode = 1;
    seen.delete();
    send_group(10, '{5, -3, 7}, 1, 0);
    wait_idle();
    chk_seen("s3", '{14, 22, 12});
    rdy_mode = 0;

    // 4: degree 1 followed back-to-back by degree 2
    seen.delete();
    send_group(-20, '{9}, 1, 0);
    send_group(3, '{-1, -1}, 1, 0);
    wait_idle();
    chk_seen("s4", '{-20, 2, 2});
    chk("s4_hd_bit", bus.hd_bit, 0);

    // Most-negative input code
    seen.delete();
    send_group(-128, '{-128}, 1, 0);
    wait_idle();
    chk_seen("neg_edge", '{-127});

    // 5: degree overflow
    seen.delete();
    send_group(0, '{1, 1, 1, 1}, 0, 0);
    wait_idle();
    chk_seen("s5", '{3, 3, 3, 3});
    chk("s5_deg_err", bus.deg_err, 1);

    // Random groups
    for (int g = 0; g < 200; g++) begin
      n = $urandom_range(1, MAX_DEG);
      msgs.delete();
      for (int k = 0; k < n; k++) msgs.push_back(rnd8());
      rdy_mode = $urandom_range(0, 2);
      send_group(rnd8(), msgs, (n < MAX_DEG) ? 1'b1 : 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2));
      if (g % 10 == 9) wait_idle();
    end
    rdy_mode = 0;
    wait_idle();

    // 6: reset mid-group, then reset while output is stalled
    send_group(5, '{2, 3}, 0, 0);
    #1 rst = 1'b1;
    #1 chk("s6a_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    rdy_mode = 3;
    send_group(7, '{4, 4}, 1, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("s6b_stalled_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6b_async_out_valid", bus.out_valid, 0);
    chk("s6b_async_in_ready", bus.in_ready, 1);
    chk("s6b_async_out_msg", int'(bus.out_msg), 0);
    repeat (2) @(negedge clk);
    rdy_mode = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    seen.delete();
    send_group(1, '{1}, 1, 0);
    wait_idle();
    chk_seen("s6_fresh", '{1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
